waveform_buffer_packer_storage: RTL and testbench

WAVEFORM_BUFFER_PACKER_STORAGE -- requirements
Module: waveform_buffer_packer_storage

---
 rtl/waveform_buffer_packer_storage.sv | 216 +++++++++++++++++++++
 tb/tb_waveform_buffer_packer_storage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_buffer_packer_storage.sv
// Waveform buffer storage: packs a sliding window of ADC/discriminator sample
// words into wide RAM words, and keeps a show-ahead header FIFO with
// drop accounting for waveform bookkeeping.
module waveform_buffer_packer_storage #(
  parameter int WORD_WIDTH      = 21,
  parameter int N_WDS_PER_WRITE = 8,
  parameter int ADR_WIDTH       = 9,
  parameter int HDR_WIDTH       = 102,
  parameter int HDR_DEPTH_LOG2  = 7,
  parameter int RD_LATENCY      = 1,
  parameter int N_WVF_WIDTH     = 16,
  localparam int DATA_WIDTH     = N_WDS_PER_WRITE*WORD_WIDTH + N_WDS_PER_WRITE/4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_WIDTH:0]       wvb_data_in,
  input  logic                      eoe_in,
  input  logic                      wvb_wrreq,
  input  logic [ADR_WIDTH-1:0]      wvb_wr_addr,
  input  logic [ADR_WIDTH-1:0]      wvb_rd_addr,
  output logic [DATA_WIDTH-1:0]     wvb_data_out,
  input  logic [HDR_WIDTH-1:0]      hdr_data_in,
  input  logic                      hdr_wrreq,
  input  logic                      hdr_rdreq,
  output logic [HDR_WIDTH-1:0]      hdr_data_out,
  output logic                      hdr_full,
  output logic                      hdr_empty,
  output logic [N_WVF_WIDTH-1:0]    n_wvf_in_buf,
  output logic                      hdr_overflow,
  output logic [15:0]               hdr_drop_cnt
);

  localparam int N_GROUPS  = N_WDS_PER_WRITE / 4;
  localparam int GRP_W     = 4*WORD_WIDTH + 1;
  localparam int HDR_DEPTH = 2**HDR_DEPTH_LOG2;
  localparam logic [HDR_DEPTH_LOG2:0] DEPTH_CNT = HDR_DEPTH[HDR_DEPTH_LOG2:0];

  // Refuse to elaborate with parameter combinations the packing or the
  // read pipeline cannot represent.
  generate
    if ((N_WDS_PER_WRITE % 4) != 0 || N_WDS_PER_WRITE < 4) begin : g_bad_nwds
      $error("N_WDS_PER_WRITE must be a positive multiple of 4");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rdlat
      $error("RD_LATENCY must be 1 or 2");
    end
    if (N_WVF_WIDTH < HDR_DEPTH_LOG2 + 1) begin : g_bad_nwvf
      $error("N_WVF_WIDTH must be at least HDR_DEPTH_LOG2+1");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sample word window
  // ---------------------------------------------------------------------
  logic                  unused_data_lsb;
  logic [WORD_WIDTH-1:0] words [N_WDS_PER_WRITE];
  logic [WORD_WIDTH-1:0] word_pipe [N_WDS_PER_WRITE-1];
  logic [DATA_WIDTH-1:0] packed_word;

  // Bit 0 of the incoming word is the legacy EOE slot and carries nothing here.
  assign unused_data_lsb = wvb_data_in[0];
  assign words[0]        = wvb_data_in[WORD_WIDTH:1];

  generate
    for (genvar k = 1; k < N_WDS_PER_WRITE; k++) begin : g_words
      assign words[k] = word_pipe[k-1];
    end
  endgenerate

  // Shift the window by one sample every cycle; reset flushes stale samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_WDS_PER_WRITE-1; k++) begin
        word_pipe[k] <= '0;
      end
    end else begin
      word_pipe[0] <= words[0];
      for (int k = 1; k < N_WDS_PER_WRITE-1; k++) begin
        word_pipe[k] <= word_pipe[k-1];
      end
    end
  end

  // Each group of four words carries one EOE bit; only the newest group
  // (at the MSB end) reports end-of-event.
  generate
    for (genvar g = 0; g < N_GROUPS; g++) begin : g_pack
      assign packed_word[DATA_WIDTH-1-g*GRP_W -: GRP_W] =
        {words[4*g], words[4*g+1], words[4*g+2], words[4*g+3],
         (g == 0) ? eoe_in : 1'b0};
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Waveform RAM
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] wvb_mem [2**ADR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q1;

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wvb_wrreq) begin
      wvb_mem[wvb_wr_addr] <= packed_word;
    end
  end

  // First read register; read-before-write gives old data on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q1 <= '0;
    end else begin
      rd_q1 <= wvb_mem[wvb_rd_addr];
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_rd_lat2
      logic [DATA_WIDTH-1:0] rd_q2;
      // Optional second read register for timing-constrained RAM macros.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q2 <= '0;
        end else begin
          rd_q2 <= rd_q1;
        end
      end
      assign wvb_data_out = rd_q2;
    end else begin : g_rd_lat1
      assign wvb_data_out = rd_q1;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Header FIFO
  // ---------------------------------------------------------------------
  logic [HDR_WIDTH-1:0]      hdr_mem [HDR_DEPTH];
  logic [HDR_DEPTH_LOG2-1:0] wr_ptr;
  logic [HDR_DEPTH_LOG2-1:0] rd_ptr;
  logic [HDR_DEPTH_LOG2:0]   count;
  logic [HDR_DEPTH_LOG2:0]   count_next;
  logic                      full_q;
  logic                      empty_q;
  logic                      overflow_q;
  logic [15:0]               drop_cnt_q;
  logic                      rd_ok;
  logic                      wr_ok;
  logic                      drop;

  // Decide which requests are honoured; a read frees a slot for a write
  // in the same cycle, but a read of an empty FIFO is never honoured.
  always_comb begin
    rd_ok      = 1'b0;
    wr_ok      = 1'b0;
    drop       = 1'b0;
    count_next = count;
    if (!rst) begin
      rd_ok = hdr_rdreq && !empty_q;
      wr_ok = hdr_wrreq && (!full_q || rd_ok);
      drop  = hdr_wrreq && full_q && !rd_ok;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + (HDR_DEPTH_LOG2+1)'(1);
      2'b01:   count_next = count - (HDR_DEPTH_LOG2+1)'(1);
      default: count_next = count;
    endcase
  end

  // Header storage; no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      hdr_mem[wr_ptr] <= hdr_data_in;
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + HDR_DEPTH_LOG2'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + HDR_DEPTH_LOG2'(1);
      end
      count   <= count_next;
      full_q  <= (count_next == DEPTH_CNT);
      empty_q <= (count_next == '0);
    end
  end

  // Sticky overflow flag and saturating count of dropped header writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign hdr_data_out = hdr_mem[rd_ptr];
  assign hdr_full     = full_q;
  assign hdr_empty    = empty_q;
  assign n_wvf_in_buf = N_WVF_WIDTH'(count);
  assign hdr_overflow = overflow_q;
  assign hdr_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_waveform_buffer_packer_storage.sv
// Scoreboard bench for waveform_buffer_packer_storage: stimulus pushes
// expected values tagged with the cycle they must appear; a negedge monitor
// pops and compares them.
module tb_waveform_buffer_packer_storage;

  localparam int WW    = 21;
  localparam int NW    = 8;
  localparam int AW    = 9;
  localparam int HW    = 102;
  localparam int HDL   = 7;
  localparam int RDL   = 1;
  localparam int NWW   = 16;
  localparam int DW    = NW*WW + NW/4;
  localparam int DEPTH = 2**HDL;

  localparam int K_WVB   = 0;
  localparam int K_HEAD  = 1;
  localparam int K_FULL  = 2;
  localparam int K_EMPTY = 3;
  localparam int K_COUNT = 4;
  localparam int K_OVF   = 5;
  localparam int K_DROP  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WW:0]   wvb_data_in = '0;
  logic          eoe_in = 1'b0;
  logic          wvb_wrreq = 1'b0;
  logic [AW-1:0] wvb_wr_addr = '0;
  logic [AW-1:0] wvb_rd_addr = '0;
  logic [DW-1:0] wvb_data_out;
  logic [HW-1:0] hdr_data_in = '0;
  logic          hdr_wrreq = 1'b0;
  logic          hdr_rdreq = 1'b0;
  logic [HW-1:0] hdr_data_out;
  logic          hdr_full;
  logic          hdr_empty;
  logic [NWW-1:0] n_wvf_in_buf;
  logic          hdr_overflow;
  logic [15:0]   hdr_drop_cnt;

  waveform_buffer_packer_storage #(
    .WORD_WIDTH(WW), .N_WDS_PER_WRITE(NW), .ADR_WIDTH(AW), .HDR_WIDTH(HW),
    .HDR_DEPTH_LOG2(HDL), .RD_LATENCY(RDL), .N_WVF_WIDTH(NWW)
  ) dut (
    .clk(clk), .rst(rst),
    .wvb_data_in(wvb_data_in), .eoe_in(eoe_in), .wvb_wrreq(wvb_wrreq),
    .wvb_wr_addr(wvb_wr_addr), .wvb_rd_addr(wvb_rd_addr), .wvb_data_out(wvb_data_out),
    .hdr_data_in(hdr_data_in), .hdr_wrreq(hdr_wrreq), .hdr_rdreq(hdr_rdreq),
    .hdr_data_out(hdr_data_out), .hdr_full(hdr_full), .hdr_empty(hdr_empty),
    .n_wvf_in_buf(n_wvf_in_buf), .hdr_overflow(hdr_overflow), .hdr_drop_cnt(hdr_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    int           kind;
    logic [255:0] val;
    string        name;
  } exp_t;

  exp_t          sb[$];
  logic [HW-1:0] model_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            mon_i;
  logic [255:0]  mon_act;

  // Known-good image of RAM[5] after words 1..8 with EOE set.
  localparam logic [DW-1:0] SPEC_RAM5 =
    {21'd8, 21'd7, 21'd6, 21'd5, 1'b1, 21'd4, 21'd3, 21'd2, 21'd1, 1'b0};

  function automatic logic [HW-1:0] hv(input int i);
    return {6'h2A, 32'(i), ~32'(i), 32'(i*7+3)};
  endfunction

  function automatic logic [255:0] pack_exp(input int b, input logic e);
    logic [DW-1:0] p;
    p = {21'(b+7), 21'(b+6), 21'(b+5), 21'(b+4), e,
         21'(b+3), 21'(b+2), 21'(b+1), 21'(b), 1'b0};
    return 256'(p);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int due, input int kind, input logic [255:0] val,
                             input string name);
    exp_t e;
    e.due  = due;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  // Drive one header-FIFO cycle and queue the state expected after the edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [HW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    hdr_wrreq   = wr;
    hdr_rdreq   = rd;
    hdr_data_in = d;
    rd_ok = rd && (model_q.size() != 0);
    wr_ok = wr && ((model_q.size() < DEPTH) || rd_ok);
    if (rd_ok) void'(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    checkOutput(cyc+1, K_COUNT, 256'(model_q.size()), "count");
    checkOutput(cyc+1, K_EMPTY, 256'(model_q.size() == 0), "empty");
    checkOutput(cyc+1, K_FULL,  256'(model_q.size() == DEPTH), "full");
    if (model_q.size() != 0) checkOutput(cyc+1, K_HEAD, 256'(model_q[0]), "head");
    step();
    hdr_wrreq = 1'b0;
    hdr_rdreq = 1'b0;
  endtask

  // Feed eight consecutive sample words, writing the packed word on the last.
  task automatic writeWave(input int b, input logic [AW-1:0] a, input logic e,
                           input logic chk_old, input logic [255:0] old);
    for (int k = 0; k < NW; k++) begin
      wvb_data_in = {21'(b+k), 1'b1};
      eoe_in      = (k == NW-1) ? e : 1'b0;
      wvb_wrreq   = (k == NW-1);
      wvb_wr_addr = a;
      if (k == NW-1 && chk_old) checkOutput(cyc+RDL, K_WVB, old, "rd_collision_old");
      step();
    end
    wvb_wrreq = 1'b0;
    eoe_in    = 1'b0;
  endtask

  // Scoreboard monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    mon_i = 0;
    while (mon_i < sb.size()) begin
      if (sb[mon_i].due <= cyc) begin
        mon_act = '0;
        case (sb[mon_i].kind)
          K_WVB:   mon_act = 256'(wvb_data_out);
          K_HEAD:  mon_act = 256'(hdr_data_out);
          K_FULL:  mon_act = 256'(hdr_full);
          K_EMPTY: mon_act = 256'(hdr_empty);
          K_COUNT: mon_act = 256'(n_wvf_in_buf);
          K_OVF:   mon_act = 256'(hdr_overflow);
          default: mon_act = 256'(hdr_drop_cnt);
        endcase
        n_checks++;
        if (mon_act !== sb[mon_i].val) begin
          n_errors++;
          $display("[TB] FAIL %s (cycle %0d): got %h expected %h",
                   sb[mon_i].name, cyc, mon_act, sb[mon_i].val);
        end
        sb.delete(mon_i);
      end else begin
        mon_i++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    checkOutput(cyc, K_EMPTY, 256'(1), "reset_empty");
    checkOutput(cyc, K_FULL,  256'(0), "reset_full");
    checkOutput(cyc, K_COUNT, 256'(0), "reset_count");
    checkOutput(cyc, K_WVB,   256'(0), "reset_wvb_out");
    checkOutput(cyc, K_OVF,   256'(0), "reset_overflow");
    checkOutput(cyc, K_DROP,  256'(0), "reset_drop_cnt");
    rst = 1'b0;
    step();

    // Waveform packing and RAM read-back
    writeWave(1, 9'd5, 1'b1, 1'b0, '0);
    wvb_rd_addr = 9'd5;
    checkOutput(cyc+RDL, K_WVB, 256'(SPEC_RAM5), "ram5_readback");
    step();
    writeWave(11, 9'd7, 1'b0, 1'b0, '0);
    wvb_rd_addr = 9'd7;
    checkOutput(cyc+RDL, K_WVB, pack_exp(11, 1'b0), "ram7_readback");
    step();
    writeWave(32'h1FFFF8, 9'd7, 1'b1, 1'b1, pack_exp(11, 1'b0));
    checkOutput(cyc+RDL, K_WVB, pack_exp(32'h1FFFF8, 1'b1), "ram7_new_data");
    step();
    wvb_rd_addr = 9'd5;
    checkOutput(cyc+RDL, K_WVB, 256'(SPEC_RAM5), "ram5_still_intact");
    step();

    // Fill the header FIFO, then overflow it once
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, hv(i));
    checkOutput(cyc, K_FULL,  256'(1), "fill_full");
    checkOutput(cyc, K_COUNT, 256'(128), "fill_count");
    checkOutput(cyc, K_HEAD,  256'(hv(0)), "fill_head");
    applyStimulus(1'b1, 1'b0, hv(500));
    checkOutput(cyc, K_OVF,  256'(1), "overflow_set");
    checkOutput(cyc, K_DROP, 256'(1), "drop_cnt_one");
    checkOutput(cyc, K_HEAD, 256'(hv(0)), "overflow_head_unchanged");

    // Simultaneous write and read while full
    applyStimulus(1'b1, 1'b1, hv(600));
    checkOutput(cyc, K_COUNT, 256'(128), "full_rw_count");
    checkOutput(cyc, K_HEAD,  256'(hv(1)), "full_rw_head");
    for (int i = 0; i < DEPTH-1; i++) applyStimulus(1'b0, 1'b1, '0);
    checkOutput(cyc, K_HEAD, 256'(hv(600)), "full_rw_tail_entry");
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(cyc, K_EMPTY, 256'(1), "drained_empty");

    // Reads of an empty FIFO are ignored
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    checkOutput(cyc, K_COUNT, 256'(0), "underflow_count");

    // Simultaneous write and read while empty
    applyStimulus(1'b1, 1'b1, hv(700));
    checkOutput(cyc, K_EMPTY, 256'(0), "empty_rw_not_empty");
    checkOutput(cyc, K_COUNT, 256'(1), "empty_rw_count");
    checkOutput(cyc, K_HEAD,  256'(hv(700)), "empty_rw_head");
    applyStimulus(1'b0, 1'b1, '0);

    // Interleaved traffic across pointer wrap
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, (i % 4) != 0, hv(1000+i));
    while (model_q.size() != 0) applyStimulus(1'b0, 1'b1, '0);
    checkOutput(cyc, K_OVF,  256'(1), "overflow_sticky");
    checkOutput(cyc, K_DROP, 256'(1), "drop_cnt_held");

    // Reset with headers queued and overflow flagged
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, hv(2000+i));
    checkOutput(cyc, K_COUNT, 256'(10), "pre_reset_count");
    rst         = 1'b1;
    hdr_wrreq   = 1'b1;
    hdr_data_in = hv(3000);
    model_q.delete();
    checkOutput(cyc+1, K_EMPTY, 256'(1), "rst_empty");
    checkOutput(cyc+1, K_COUNT, 256'(0), "rst_count");
    checkOutput(cyc+1, K_FULL,  256'(0), "rst_full");
    checkOutput(cyc+1, K_OVF,   256'(0), "rst_overflow");
    checkOutput(cyc+1, K_DROP,  256'(0), "rst_drop_cnt");
    checkOutput(cyc+1, K_WVB,   256'(0), "rst_wvb_out");
    step();
    rst         = 1'b0;
    hdr_wrreq   = 1'b0;
    wvb_rd_addr = 9'd5;
    checkOutput(cyc+RDL, K_WVB, 256'(SPEC_RAM5), "ram5_after_reset");
    checkOutput(cyc+1, K_EMPTY, 256'(1), "reset_write_lost");
    step();

    for (int t = 0; t < 20 && sb.size() != 0; t++) step();
    if (sb.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
